// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the GPU pipeline stages: datapath widths, opcode
// constants, instruction field positions and the opcode -> class decode.
// No ports (package).
// ---------------------------------------------------------------------------
package gpu_pkg;

    localparam int NUM_REGS      = 16;
    localparam int REG_IDX_WIDTH = $clog2(NUM_REGS);
    localparam int DATA_WIDTH    = 16;
    localparam int PC_WIDTH      = 16;
    localparam int IR_WIDTH      = 32;
    localparam int OPCODE_WIDTH  = 8;

    // Instruction layout: opcode | dest | src1 | src2 | (imm overlaps src2)
    localparam int IR_OPCODE_LSB = 24;
    localparam int IR_DEST_LSB   = 20;
    localparam int IR_SRC1_LSB   = 16;
    localparam int IR_SRC2_LSB   = 12;
    localparam int IR_IMM_LSB    = 0;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 8'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 8'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI = 8'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_BR   = 8'h10;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZ  = 8'h11;
    localparam logic [OPCODE_WIDTH-1:0] OP_ST   = 8'h20;
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 8'hFF;

    typedef struct packed {
        logic readsSrc1;
        logic readsSrc2;
        logic writesDest;
        logic isBranch;
    } opClass_t;

    // Unknown opcodes decode like NOP: they touch no registers and never stall.
    function automatic opClass_t decodeClass(input logic [OPCODE_WIDTH-1:0] opcode);
        opClass_t cls;
        cls = '0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                cls.readsSrc1  = 1'b1;
                cls.readsSrc2  = 1'b1;
                cls.writesDest = 1'b1;
            end
            OP_ADDI: begin
                cls.readsSrc1  = 1'b1;
                cls.writesDest = 1'b1;
            end
            OP_MOVI: cls.writesDest = 1'b1;
            OP_BR:   cls.isBranch   = 1'b1;
            OP_BRZ: begin
                cls.readsSrc1 = 1'b1;
                cls.isBranch  = 1'b1;
            end
            OP_ST: begin
                cls.readsSrc1 = 1'b1;
                cls.readsSrc2 = 1'b1;
            end
            default: cls = '0;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Bundles the fetch-side inputs, writeback/control inputs and the issue-side
// outputs of the decode stage.
//   master : drives the I_* signals, observes the O_* signals (fetch/env side)
//   slave  : the decode stage itself
// ---------------------------------------------------------------------------
interface decode_stage_if;

    logic                            I_LOCK;
    logic [gpu_pkg::PC_WIDTH-1:0]    I_PC;
    logic [gpu_pkg::IR_WIDTH-1:0]    I_IR;
    logic                            I_FE_Valid;
    logic                            I_BranchAddrSelect;
    logic                            I_GPUStallSignal;
    logic                            I_WB_Enable;
    logic [gpu_pkg::REG_IDX_WIDTH-1:0] I_WB_RegIdx;
    logic [gpu_pkg::DATA_WIDTH-1:0]  I_WB_Data;

    logic                            O_LOCK;
    logic [gpu_pkg::PC_WIDTH-1:0]    O_PC;
    logic [gpu_pkg::OPCODE_WIDTH-1:0] O_Opcode;
    logic [gpu_pkg::REG_IDX_WIDTH-1:0] O_DestRegIdx;
    logic [gpu_pkg::DATA_WIDTH-1:0]  O_Src1Value;
    logic [gpu_pkg::DATA_WIDTH-1:0]  O_Src2Value;
    logic [gpu_pkg::DATA_WIDTH-1:0]  O_Imm;
    logic                            O_DE_Valid;
    logic                            O_BranchStallSignal;
    logic                            O_DepStallSignal;

    modport master (
        output I_LOCK, I_PC, I_IR, I_FE_Valid, I_BranchAddrSelect, I_GPUStallSignal,
               I_WB_Enable, I_WB_RegIdx, I_WB_Data,
        input  O_LOCK, O_PC, O_Opcode, O_DestRegIdx, O_Src1Value, O_Src2Value, O_Imm,
               O_DE_Valid, O_BranchStallSignal, O_DepStallSignal
    );

    modport slave (
        input  I_LOCK, I_PC, I_IR, I_FE_Valid, I_BranchAddrSelect, I_GPUStallSignal,
               I_WB_Enable, I_WB_RegIdx, I_WB_Data,
        output O_LOCK, O_PC, O_Opcode, O_DestRegIdx, O_Src1Value, O_Src2Value, O_Imm,
               O_DE_Valid, O_BranchStallSignal, O_DepStallSignal
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Architectural register file with writeback bypass on both read ports, plus
// one busy bit per register tracking in-flight destinations.
//   clk_i, rst_ni            : negedge clock, async active-low reset
//   wbEnable_i/wbIdx_i/wbData_i : writeback port (writes array, clears busy)
//   src1Idx_i/src2Idx_i      : read indices -> src1Value_o/src2Value_o
//   destIdx_i, setEnable_i   : mark destIdx_i busy (issue of a writer)
//   clearAll_i               : drop every busy bit (pipeline flush)
//   src1Busy_o/src2Busy_o/destBusy_o : busy bits, ignoring ones cleared now
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import gpu_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wbEnable_i,
    input  logic [REG_IDX_WIDTH-1:0] wbIdx_i,
    input  logic [DATA_WIDTH-1:0]    wbData_i,
    input  logic [REG_IDX_WIDTH-1:0] src1Idx_i,
    input  logic [REG_IDX_WIDTH-1:0] src2Idx_i,
    input  logic [REG_IDX_WIDTH-1:0] destIdx_i,
    input  logic                     setEnable_i,
    input  logic                     clearAll_i,
    output logic [DATA_WIDTH-1:0]    src1Value_o,
    output logic [DATA_WIDTH-1:0]    src2Value_o,
    output logic                     src1Busy_o,
    output logic                     src2Busy_o,
    output logic                     destBusy_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [NUM_REGS-1:0]   wbClear;
    logic [NUM_REGS-1:0]   setMask;
    logic [NUM_REGS-1:0]   busyEff;

    // The OR with setMask comes after the clear so a same-index set wins.
    always_comb begin
        wbClear = '0;
        setMask = '0;
        if (wbEnable_i) wbClear[wbIdx_i] = 1'b1;
        if (setEnable_i) setMask[destIdx_i] = 1'b1;
        busyEff = busy_q & ~wbClear;
        if (clearAll_i) busy_d = '0;
        else            busy_d = busyEff | setMask;
    end

    assign src1Busy_o = busyEff[src1Idx_i];
    assign src2Busy_o = busyEff[src2Idx_i];
    assign destBusy_o = busyEff[destIdx_i];

    assign src1Value_o = (wbEnable_i && (wbIdx_i == src1Idx_i)) ? wbData_i : regs_q[src1Idx_i];
    assign src2Value_o = (wbEnable_i && (wbIdx_i == src2Idx_i)) ? wbData_i : regs_q[src2Idx_i];

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            if (wbEnable_i) regs_q[wbIdx_i] <= wbData_i;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Decodes the fetched instruction, reads operands, detects register and
// branch hazards and latches the issued instruction for execute.
//   I_CLOCK   : stage clock, state changes on the falling edge
//   I_RESET_N : asynchronous active-low reset
//   bus       : decode_stage_if.slave (fetch inputs, writeback, issue outputs)
// ---------------------------------------------------------------------------
module decode_stage
    import gpu_pkg::*;
(
    input logic           I_CLOCK,
    input logic           I_RESET_N,
    decode_stage_if.slave bus
);

    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [REG_IDX_WIDTH-1:0] destIdx;
    logic [REG_IDX_WIDTH-1:0] src1Idx;
    logic [REG_IDX_WIDTH-1:0] src2Idx;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    src1Value;
    logic [DATA_WIDTH-1:0]    src2Value;
    opClass_t                 opClass;
    logic                     src1Busy, src2Busy, destBusy;
    logic                     depHazard;
    logic                     issue;

    logic                     lock_q, lock_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [OPCODE_WIDTH-1:0]  opcode_q, opcode_d;
    logic [REG_IDX_WIDTH-1:0] destIdx_q, destIdx_d;
    logic [DATA_WIDTH-1:0]    src1Value_q, src1Value_d;
    logic [DATA_WIDTH-1:0]    src2Value_q, src2Value_d;
    logic [DATA_WIDTH-1:0]    imm_q, imm_d;
    logic                     deValid_q, deValid_d;
    logic                     branchPending_q, branchPending_d;

    assign opcode  = bus.I_IR[IR_OPCODE_LSB +: OPCODE_WIDTH];
    assign destIdx = bus.I_IR[IR_DEST_LSB +: REG_IDX_WIDTH];
    assign src1Idx = bus.I_IR[IR_SRC1_LSB +: REG_IDX_WIDTH];
    assign src2Idx = bus.I_IR[IR_SRC2_LSB +: REG_IDX_WIDTH];
    assign imm     = bus.I_IR[IR_IMM_LSB +: DATA_WIDTH];
    assign opClass = decodeClass(opcode);

    regfile_scoreboard u_regfile (
        .clk_i       (I_CLOCK),
        .rst_ni      (I_RESET_N),
        .wbEnable_i  (bus.I_WB_Enable),
        .wbIdx_i     (bus.I_WB_RegIdx),
        .wbData_i    (bus.I_WB_Data),
        .src1Idx_i   (src1Idx),
        .src2Idx_i   (src2Idx),
        .destIdx_i   (destIdx),
        .setEnable_i (issue && opClass.writesDest),
        .clearAll_i  (!bus.I_LOCK),
        .src1Value_o (src1Value),
        .src2Value_o (src2Value),
        .src1Busy_o  (src1Busy),
        .src2Busy_o  (src2Busy),
        .destBusy_o  (destBusy)
    );

    // While a branch is pending, fetch is already held by the branch stall,
    // so a register hazard is not reported on top of it. The dest check
    // prevents a second writer overtaking an older in-flight write.
    assign depHazard = bus.I_FE_Valid && !branchPending_q &&
                       ((opClass.readsSrc1  && src1Busy) ||
                        (opClass.readsSrc2  && src2Busy) ||
                        (opClass.writesDest && destBusy));

    assign issue = bus.I_LOCK && bus.I_FE_Valid && !depHazard &&
                   !branchPending_q && !bus.I_GPUStallSignal;

    // Next-state: flush beats GPU stall beats issue; a branch resolution
    // clearing the pending flag beats a new branch setting it.
    always_comb begin
        lock_d          = bus.I_LOCK;
        pc_d            = pc_q;
        opcode_d        = opcode_q;
        destIdx_d       = destIdx_q;
        src1Value_d     = src1Value_q;
        src2Value_d     = src2Value_q;
        imm_d           = imm_q;
        deValid_d       = deValid_q;
        branchPending_d = branchPending_q;
        if (!bus.I_LOCK) begin
            deValid_d       = 1'b0;
            branchPending_d = 1'b0;
        end else begin
            if (bus.I_BranchAddrSelect) begin
                branchPending_d = 1'b0;
            end else if (issue && opClass.isBranch) begin
                branchPending_d = 1'b1;
            end
            if (bus.I_GPUStallSignal) begin
                deValid_d = deValid_q;
            end else if (issue) begin
                pc_d        = bus.I_PC;
                opcode_d    = opcode;
                destIdx_d   = destIdx;
                src1Value_d = src1Value;
                src2Value_d = src2Value;
                imm_d       = imm;
                deValid_d   = 1'b1;
            end else begin
                deValid_d = 1'b0;
            end
        end
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            lock_q          <= 1'b0;
            pc_q            <= '0;
            opcode_q        <= OP_NOP;
            destIdx_q       <= '0;
            src1Value_q     <= '0;
            src2Value_q     <= '0;
            imm_q           <= '0;
            deValid_q       <= 1'b0;
            branchPending_q <= 1'b0;
        end else begin
            lock_q          <= lock_d;
            pc_q            <= pc_d;
            opcode_q        <= opcode_d;
            destIdx_q       <= destIdx_d;
            src1Value_q     <= src1Value_d;
            src2Value_q     <= src2Value_d;
            imm_q           <= imm_d;
            deValid_q       <= deValid_d;
            branchPending_q <= branchPending_d;
        end
    end

    assign bus.O_LOCK              = lock_q;
    assign bus.O_PC                = pc_q;
    assign bus.O_Opcode            = opcode_q;
    assign bus.O_DestRegIdx        = destIdx_q;
    assign bus.O_Src1Value         = src1Value_q;
    assign bus.O_Src2Value         = src2Value_q;
    assign bus.O_Imm               = imm_q;
    assign bus.O_DE_Valid          = deValid_q;
    assign bus.O_BranchStallSignal = branchPending_q;
    assign bus.O_DepStallSignal    = depHazard && bus.I_LOCK;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Directed test of decode_stage: reset, RAW stall with bypass, branch stall,
// GPU stall, simultaneous writeback/issue on one register, lock drop and an
// asynchronous reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic clk = 1'b1;
    logic rstN;
    int   vectors = 0;
    int   miscompares = 0;

    decode_stage_if bus();

    decode_stage dut (
        .I_CLOCK   (clk),
        .I_RESET_N (rstN),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Drive inputs shortly after a falling edge, then settle before checks.
    task automatic applyStimulus(input logic lock, input logic feValid, input logic [15:0] pc,
                                 input logic [31:0] ir, input logic bas, input logic gpu,
                                 input logic wbEn, input logic [3:0] wbIdx, input logic [15:0] wbData);
        bus.I_LOCK             = lock;
        bus.I_FE_Valid         = feValid;
        bus.I_PC               = pc;
        bus.I_IR               = ir;
        bus.I_BranchAddrSelect = bas;
        bus.I_GPUStallSignal   = gpu;
        bus.I_WB_Enable        = wbEn;
        bus.I_WB_RegIdx        = wbIdx;
        bus.I_WB_Data          = wbData;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 32'hFF00_0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("rst_opcode", 32'(bus.O_Opcode), 32'h0000_00FF);
        checkOutput("rst_valid", 32'(bus.O_DE_Valid), 32'h0);
        checkOutput("rst_pc", 32'(bus.O_PC), 32'h0);
        checkOutput("rst_lock", 32'(bus.O_LOCK), 32'h0);
        checkOutput("rst_brstall", 32'(bus.O_BranchStallSignal), 32'h0);
        checkOutput("rst_depstall", 32'(bus.O_DepStallSignal), 32'h0);
        tick();
        rstN = 1'b1;

        // Preload r1, r2, r7 through the writeback port.
        applyStimulus(1'b1, 1'b0, 16'h0000, 32'hFF00_0000, 1'b0, 1'b0, 1'b1, 4'h1, 16'h0011);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0000, 32'hFF00_0000, 1'b0, 1'b0, 1'b1, 4'h2, 16'h0022);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0000, 32'hFF00_0000, 1'b0, 1'b0, 1'b1, 4'h7, 16'h0077);
        tick();

        // NOP after reset issues without stalls.
        applyStimulus(1'b1, 1'b1, 16'h0004, 32'hFF00_0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        checkOutput("nop_depstall", 32'(bus.O_DepStallSignal), 32'h0);
        tick();
        checkOutput("nop_valid", 32'(bus.O_DE_Valid), 32'h1);
        checkOutput("nop_opcode", 32'(bus.O_Opcode), 32'h0000_00FF);
        checkOutput("nop_pc", 32'(bus.O_PC), 32'h0004);
        checkOutput("nop_brstall", 32'(bus.O_BranchStallSignal), 32'h0);
        checkOutput("nop_lock", 32'(bus.O_LOCK), 32'h1);

        // ADD r3 <- r1, r2
        applyStimulus(1'b1, 1'b1, 16'h0008, 32'h0131_2000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        checkOutput("add1_depstall", 32'(bus.O_DepStallSignal), 32'h0);
        tick();
        checkOutput("add1_valid", 32'(bus.O_DE_Valid), 32'h1);
        checkOutput("add1_opcode", 32'(bus.O_Opcode), 32'h01);
        checkOutput("add1_dest", 32'(bus.O_DestRegIdx), 32'h3);
        checkOutput("add1_src1", 32'(bus.O_Src1Value), 32'h0011);
        checkOutput("add1_src2", 32'(bus.O_Src2Value), 32'h0022);
        checkOutput("add1_imm", 32'(bus.O_Imm), 32'h2000);

        // ADD r4 <- r3, r1 stalls on r3 for two cycles.
        applyStimulus(1'b1, 1'b1, 16'h000C, 32'h0143_1000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        checkOutput("raw_depstall_c1", 32'(bus.O_DepStallSignal), 32'h1);
        tick();
        checkOutput("raw_valid_c1", 32'(bus.O_DE_Valid), 32'h0);
        checkOutput("raw_depstall_c2", 32'(bus.O_DepStallSignal), 32'h1);
        tick();
        checkOutput("raw_valid_c2", 32'(bus.O_DE_Valid), 32'h0);
        // Third cycle: writeback r3 releases the stall via the bypass.
        applyStimulus(1'b1, 1'b1, 16'h000C, 32'h0143_1000, 1'b0, 1'b0, 1'b1, 4'h3, 16'h0042);
        checkOutput("raw_depstall_wb", 32'(bus.O_DepStallSignal), 32'h0);
        tick();
        checkOutput("raw_valid_wb", 32'(bus.O_DE_Valid), 32'h1);
        checkOutput("raw_src1_bypass", 32'(bus.O_Src1Value), 32'h0042);
        checkOutput("raw_src2", 32'(bus.O_Src2Value), 32'h0011);
        checkOutput("raw_dest", 32'(bus.O_DestRegIdx), 32'h4);
        checkOutput("raw_pc", 32'(bus.O_PC), 32'h000C);

        // Branch at PC 0x0010.
        applyStimulus(1'b1, 1'b1, 16'h0010, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();
        checkOutput("br_valid", 32'(bus.O_DE_Valid), 32'h1);
        checkOutput("br_pc", 32'(bus.O_PC), 32'h0010);
        checkOutput("br_brstall", 32'(bus.O_BranchStallSignal), 32'h1);
        applyStimulus(1'b1, 1'b1, 16'h0014, 32'h0151_2000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        checkOutput("br_depstall", 32'(bus.O_DepStallSignal), 32'h0);
        tick();
        checkOutput("br_blocked_valid", 32'(bus.O_DE_Valid), 32'h0);
        checkOutput("br_blocked_brstall", 32'(bus.O_BranchStallSignal), 32'h1);
        applyStimulus(1'b1, 1'b1, 16'h0020, 32'h0151_2000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();
        checkOutput("br_resolve_valid", 32'(bus.O_DE_Valid), 32'h0);
        checkOutput("br_resolve_brstall", 32'(bus.O_BranchStallSignal), 32'h0);
        applyStimulus(1'b1, 1'b1, 16'h0020, 32'h0151_2000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();
        checkOutput("br_after_valid", 32'(bus.O_DE_Valid), 32'h1);
        checkOutput("br_after_pc", 32'(bus.O_PC), 32'h0020);
        checkOutput("br_after_dest", 32'(bus.O_DestRegIdx), 32'h5);

        // GPU stall for three cycles with ADD r6 <- r1, r2 presented.
        applyStimulus(1'b1, 1'b1, 16'h0024, 32'h0161_2000, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("gpu_hold_valid", 32'(bus.O_DE_Valid), 32'h1);
            checkOutput("gpu_hold_pc", 32'(bus.O_PC), 32'h0020);
            checkOutput("gpu_hold_dest", 32'(bus.O_DestRegIdx), 32'h5);
        end
        applyStimulus(1'b1, 1'b1, 16'h0024, 32'h0161_2000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        checkOutput("gpu_resume_depstall", 32'(bus.O_DepStallSignal), 32'h0);
        tick();
        checkOutput("gpu_resume_valid", 32'(bus.O_DE_Valid), 32'h1);
        checkOutput("gpu_resume_pc", 32'(bus.O_PC), 32'h0024);
        checkOutput("gpu_resume_dest", 32'(bus.O_DestRegIdx), 32'h6);

        // MOVI r5 issues while r5 is written back: r5 must stay busy.
        applyStimulus(1'b1, 1'b1, 16'h0028, 32'h0450_00AB, 1'b0, 1'b0, 1'b1, 4'h5, 16'h0055);
        checkOutput("setclr_depstall", 32'(bus.O_DepStallSignal), 32'h0);
        tick();
        checkOutput("setclr_valid", 32'(bus.O_DE_Valid), 32'h1);
        checkOutput("setclr_imm", 32'(bus.O_Imm), 32'h00AB);
        applyStimulus(1'b1, 1'b1, 16'h002C, 32'h0185_1000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        checkOutput("setclr_busy5", 32'(bus.O_DepStallSignal), 32'h1);
        tick();
        checkOutput("setclr_stall_valid", 32'(bus.O_DE_Valid), 32'h0);

        // Make r7 busy and a branch pending, then drop lock.
        applyStimulus(1'b1, 1'b1, 16'h0030, 32'h0470_0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();
        checkOutput("movi7_valid", 32'(bus.O_DE_Valid), 32'h1);
        applyStimulus(1'b1, 1'b1, 16'h0034, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();
        checkOutput("br2_brstall", 32'(bus.O_BranchStallSignal), 32'h1);
        applyStimulus(1'b0, 1'b1, 16'h0038, 32'h0197_1000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        tick();
        checkOutput("lock_valid", 32'(bus.O_DE_Valid), 32'h0);
        checkOutput("lock_brstall", 32'(bus.O_BranchStallSignal), 32'h0);
        checkOutput("lock_depstall", 32'(bus.O_DepStallSignal), 32'h0);
        checkOutput("lock_olock", 32'(bus.O_LOCK), 32'h0);
        applyStimulus(1'b1, 1'b1, 16'h0038, 32'h0197_1000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        checkOutput("relock_depstall", 32'(bus.O_DepStallSignal), 32'h0);
        tick();
        checkOutput("relock_valid", 32'(bus.O_DE_Valid), 32'h1);
        checkOutput("relock_src1_r7", 32'(bus.O_Src1Value), 32'h0077);
        checkOutput("relock_src2_r1", 32'(bus.O_Src2Value), 32'h0011);

        // Asynchronous reset between edges.
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(bus.O_DE_Valid), 32'h0);
        checkOutput("midrst_opcode", 32'(bus.O_Opcode), 32'h0000_00FF);
        checkOutput("midrst_pc", 32'(bus.O_PC), 32'h0);
        checkOutput("midrst_src1", 32'(bus.O_Src1Value), 32'h0);
        checkOutput("midrst_lock", 32'(bus.O_LOCK), 32'h0);
        rstN = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h0040, 32'h01A1_9000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
        checkOutput("postrst_depstall", 32'(bus.O_DepStallSignal), 32'h0);
        tick();
        checkOutput("postrst_valid", 32'(bus.O_DE_Valid), 32'h1);
        checkOutput("postrst_src1", 32'(bus.O_Src1Value), 32'h0);
        checkOutput("postrst_pc", 32'(bus.O_PC), 32'h0040);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of instruction fetch. Consumes fetched PC/IR/valid and decodes the instruction.
- Reads the 16-entry register file and tracks in-flight destination registers with a scoreboard.
- Issues decoded operands to execute.
- Generates the branch-stall and dependency-stall signals that fetch uses to hold or invalidate its latch.

Parameters:
- NUM_REGS, 16, architectural register count (index width = clog2(NUM_REGS) = 4)
- DATA_WIDTH, 16, register/operand width
- PC_WIDTH, 16, program counter width
- IR_WIDTH, 32, instruction width

Ports:
- I_CLOCK in 1: stage clock; all state updates on negedge, same as fetch.
- I_RESET_N in 1: asynchronous, active-low reset.
- I_LOCK in 1: pipeline run enable; 0 = flush/idle.
- I_PC in PC_WIDTH: PC of the fetched instruction.
- I_IR in IR_WIDTH: fetched instruction.
- I_FE_Valid in 1: fetched instruction is valid.
- I_BranchAddrSelect in 1: branch resolved (pulse from memory stage).
- I_GPUStallSignal in 1: downstream GPU stall; freeze the stage.
- I_WB_Enable in 1: writeback strobe.
- I_WB_RegIdx in 4: writeback destination register.
- I_WB_Data in DATA_WIDTH: writeback value.
- O_LOCK out 1: registered copy of I_LOCK.
- O_PC out PC_WIDTH: PC of the issued instruction.
- O_Opcode out 8: IR[31:24].
- O_DestRegIdx out 4: IR[23:20].
- O_Src1Value out DATA_WIDTH: operand 1 (register read of IR[19:16]).
- O_Src2Value out DATA_WIDTH: operand 2 (register read of IR[15:12]).
- O_Imm out DATA_WIDTH: IR[15:0].
- O_DE_Valid out 1: issued instruction valid.
- O_BranchStallSignal out 1: to fetch.
- O_DepStallSignal out 1: to fetch; combinational.

Behaviour:
- Reset (I_RESET_N=0, asynchronous):
  - All outputs 0, except O_Opcode=8'hFF (NOP).
  - Register file all 0; scoreboard all clear; branch-pending flag clear.
- Instruction format: opcode [31:24], dest [23:20], src1 [19:16], src2 [15:12], imm [15:0].
- Per-opcode class bits come from a package function:
  - reads_src1, reads_src2, writes_dest, is_branch.
  - NOP 8'hFF has all class bits 0.
- Register reads are combinational with writeback bypass: if I_WB_Enable and I_WB_RegIdx == srcN, operand = I_WB_Data.
- Register file write: on negedge when I_WB_Enable.
- Scoreboard (busy bit per register):
  - Clear on writeback to that index.
  - Set when an instruction with writes_dest issues.
  - Set and clear on the same index in the same cycle: set wins.
- dep_hazard (combinational): I_FE_Valid && !branch_pending && any of:
  - (reads_src1 && busy[src1]), (reads_src2 && busy[src2]), (writes_dest && busy[dest]).
  - A busy bit being cleared this cycle by writeback is treated as not busy.
- O_DepStallSignal = dep_hazard && I_LOCK.
- Branch-pending flag:
  - Set when a valid is_branch instruction issues.
  - Clear on I_BranchAddrSelect.
  - Set and clear in the same cycle: clear wins.
- O_BranchStallSignal = branch_pending (registered), so it rises one cycle after the branch issues.
- Issue condition: I_LOCK && I_FE_Valid && !dep_hazard && !branch_pending && !I_GPUStallSignal. Latency 1 cycle from fetch latch to output latch.
- Per cycle (negedge), in priority order:
  - I_LOCK=0: O_DE_Valid←0, scoreboard and branch_pending cleared, register file retained.
  - I_GPUStallSignal=1: all outputs hold; scoreboard updates only from writeback.
  - Issue condition true: latch PC/opcode/indices/operands/imm, O_DE_Valid←1.
  - Otherwise: O_DE_Valid←0 (bubble); other outputs don't-care but hold.
- O_LOCK←I_LOCK every negedge.
- Reset mid-operation: immediate return to reset values; any in-flight branch or scoreboard state is discarded.

Decomposition:
- Shared package (gpu_pkg): opcode constants (including OP_NOP=8'hFF), IR field bit positions, REG_IDX_WIDTH, and the opcode→class decode function (also used by execute).
- One natural sub-module: regfile_scoreboard, holding the register array, the bypass read, and the busy bits with set/clear priority.
- Decode control and the output latch stay in the top level.

Test Plan:
- Reset: drive I_RESET_N low mid-cycle → all outputs 0, O_Opcode=FF, immediately (asynchronous); after release, a NOP input gives O_DE_Valid=1 and no stalls.
- RAW stall:
  - Stimulus: issue ADD r3←r1,r2, then ADD r4←r3,r1; writeback r3=16'h0042 three cycles later.
  - Response: O_DepStallSignal=1 and O_DE_Valid=0 until the writeback cycle; on that cycle the bypass gives O_Src1Value=16'h0042 and issue proceeds.
- Branch:
  - Stimulus: issue a branch at PC 16'h0010.
  - Response: O_BranchStallSignal=1 from the next cycle; following valid inputs are not issued; after the I_BranchAddrSelect pulse, stall drops and the next instruction issues.
- GPU stall: assert I_GPUStallSignal for 3 cycles with a valid input → all outputs frozen, no scoreboard set; resumes issuing after deassert.
- Simultaneous writeback and issue to the same register: WB r5 while issuing a writer of r5 → busy[5] remains 1.
- Lock drop: I_LOCK=0 while r7 is busy and a branch is pending → O_DE_Valid=0, both stalls 0; register contents preserved.
